pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register that supersedes the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W datapath payload and a CTRL_W control bundle between two pipeline stages.
- Uses a valid/ready handshake in place of a bare latch enable.
- Adds a synchronous flush that inserts a bubble, an optional 2-entry skid buffer that breaks the ready path, and a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32: width of payload (register data, immediates, register indices).
- CTRL_W, 12: width of control bundle (ALU op, RegWrite, MemWrite, ...); zeroed on flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_DATA, 0: 1 = flush/bubble also zeroes payload; 0 = payload holds its last value.
- CNT_W, 16: width of bubble_count.

Ports:
- clk, in, 1: clock; all state changes on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous squash of all held entries (branch/hazard clear).
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept a beat.
- in_data, in, DATA_W: upstream payload.
- in_ctrl, in, CTRL_W: upstream control bundle.
- out_valid, out, 1: downstream beat present.
- out_ready, in, 1: downstream accepts (0 = stall).
- out_data, out, DATA_W: head payload.
- out_ctrl, out, CTRL_W: head control; all-zero whenever out_valid=0.
- occupancy, out, 2: number of held entries (0..2; max 1 when SKID=0).
- bubble_count, out, CNT_W: saturating count of cycles with out_ready=1 and out_valid=0.

Behaviour:
- Reset (reset=0, asynchronous): all entries invalid, out_data=0, out_ctrl=0, occupancy=0, bubble_count=0. in_ready=1 for SKID=0; 0 while in reset, then 1 from the first edge after release, for SKID=1.
- Accept when in_valid & in_ready. Emit when out_valid & out_ready. Strict FIFO order; no beat is duplicated or lost except by flush.
- Latency: an accepted beat appears on out_* the cycle after acceptance (1 cycle) when the stage was empty or draining.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Simultaneous accept and emit replaces the head in one cycle, so throughput is 1 beat/cycle.
- SKID=1 states:
  - EMPTY (occ 0): accept -> HALF.
  - HALF (occ 1): accept & !emit -> FULL; emit & !accept -> EMPTY; accept & emit -> HALF with the new head.
  - FULL (occ 2): in_ready=0; emit -> HALF, and the skid entry moves to the head the same cycle.
  - in_ready is registered: in_ready = (next occupancy < 2).
  - Full throughput of 1 beat/cycle is sustained with no combinational path from out_ready to in_ready.
- out_ctrl and (if CLEAR_DATA=1) out_data are forced to 0 whenever the head is invalid, so a bubble is a guaranteed NOP.
- Flush (flush=1 at an edge):
  - All entries are invalidated and occupancy becomes 0.
  - Any beat accepted in the same cycle is discarded.
  - Any beat emitted in the same cycle counts as delivered.
  - Flush has priority over accept. in_ready is 1 on the following cycle.
- bubble_count: increments when out_ready=1 and out_valid=0; saturates at 2^CNT_W-1; cleared only by reset. Flush does not clear it.
- Reset asserted mid-transfer: state clears immediately and asynchronously; no partial beat is presented after release.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage control-bundle typedefs (ex_ctrl_t, mem_ctrl_t, wb_ctrl_t);
  - their widths as constants, so instances set CTRL_W from the package;
  - the NOP control constant (all-zero).
- One natural sub-module, pipe_skid_entry: one valid+ctrl+data register slot with load/clear. It is instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
- Reset release, SKID=1: hold reset=0 for 3 cycles, then release -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 one cycle after release; bubble_count counts from 0 once out_ready=1.
- Streaming: send 8 beats with in_data=0x10..0x17 and out_ready=1 -> outputs 0x10..0x17 in order, one per cycle, first output 1 cycle after first accept, occupancy never exceeds 1.
- Backpressure, SKID=1: out_ready=0 while sending 0xA0,0xA1,0xA2 -> 0xA0 and 0xA1 held, in_ready=0 after 2 accepts, 0xA2 is stalled upstream. Release out_ready -> outputs 0xA0,0xA1,0xA2 in order with no loss.
- Flush with simultaneous accept: occupancy=2 and in_valid=1 with in_data=0x55 while flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and 0x55 never appears.
- Bubble counter saturation, CNT_W=4: out_ready=1 and in_valid=0 for 20 cycles -> bubble_count=15 and holds; a following flush leaves it at 15.
- SKID=0 stall: out_ready=0 with stage full -> in_ready=0 in the same cycle. Raise out_ready together with in_valid -> head replaced in one cycle, throughput 1 beat/cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: per-stage control bundles, their widths,
// the all-zero NOP bundle, and the occupancy encoding of a stage register.
package pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic link;
  } wb_ctrl_t;

  localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
  localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

  // Control width carried by each boundary: later stages drop consumed fields.
  localparam int ID_EX_CTRL_W  = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
  localparam int EX_MEM_CTRL_W = MEM_CTRL_W + WB_CTRL_W;
  localparam int MEM_WB_CTRL_W = WB_CTRL_W;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_ctrl_t;

  // A bubble must never write anything: all control fields low.
  localparam id_ex_ctrl_t ID_EX_NOP = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake between two pipeline stages, upstream (in_*) and
// downstream (out_*) sides. master = the environment, slave = the stage.
interface pipe_stage_reg_if import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = ID_EX_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg_skid_entry.sv
// One register slot of a pipeline stage: valid flag, control and payload.
// clear wins over load; clearing always zeroes control so an empty slot is
// a NOP, and zeroes the payload only when CLEAR_DATA is set.
module pipe_skid_entry import pipe_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = ID_EX_CTRL_W,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  // Next slot contents: clear, load or hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA != 0) data_d = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end
  end

  // Slot register; reset empties the slot and zeroes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, synchronous
// flush, optional two-entry skid buffer (registered in_ready) and a
// saturating bubble counter for performance monitoring.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = ID_EX_CTRL_W,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_count
);
  logic              accept, emit;
  logic              h_load, h_clear, h_valid;
  logic [DATA_W-1:0] h_d_data, h_data;
  logic [CTRL_W-1:0] h_d_ctrl, h_ctrl;
  logic [CNT_W-1:0]  bubble_d, bubble_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = h_valid & bus.out_ready;

  // ---- head slot: drives the downstream side ----
  pipe_skid_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)
  ) u_head (
    .clk(clk), .reset(reset), .load(h_load), .clear(h_clear),
    .d_data(h_d_data), .d_ctrl(h_d_ctrl),
    .q_valid(h_valid), .q_data(h_data), .q_ctrl(h_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              s_load, s_clear, s_valid;
      logic [DATA_W-1:0] s_data;
      logic [CTRL_W-1:0] s_ctrl;
      logic [1:0]        occ_d;
      logic              in_ready_d, in_ready_q;

      // ---- skid slot: catches the beat accepted while the head stalls ----
      pipe_skid_entry #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)
      ) u_skid (
        .clk(clk), .reset(reset), .load(s_load), .clear(s_clear),
        .d_data(bus.in_data), .d_ctrl(bus.in_ctrl),
        .q_valid(s_valid), .q_data(s_data), .q_ctrl(s_ctrl)
      );

      assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};

      // Slot steering per occupancy state; the skid refills the head on emit.
      always_comb begin
        h_load   = 1'b0;
        h_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        h_d_data = bus.in_data;
        h_d_ctrl = bus.in_ctrl;
        if (flush) begin
          h_clear = 1'b1;
          s_clear = 1'b1;
        end else begin
          case (occ_state_t'(occupancy))
            OCC_EMPTY: h_load = accept;
            OCC_HALF: begin
              if (accept && emit)  h_load  = 1'b1;
              else if (accept)     s_load  = 1'b1;
              else if (emit)       h_clear = 1'b1;
            end
            OCC_FULL: begin
              if (emit) begin
                h_load   = 1'b1;
                h_d_data = s_data;
                h_d_ctrl = s_ctrl;
                s_clear  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      // Ready for next cycle depends only on next occupancy, never on out_ready now.
      always_comb begin
        occ_d      = flush ? 2'd0 : occupancy + {1'b0, accept} - {1'b0, emit};
        in_ready_d = (occ_d < 2'd2);
      end

      // Registered in_ready; low while in reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_ready_q <= 1'b0;
        else        in_ready_q <= in_ready_d;
      end

      assign bus.in_ready = in_ready_q;
    end else begin : g_single
      assign occupancy    = {1'b0, h_valid};
      assign bus.in_ready = !h_valid | bus.out_ready;

      // Single slot: accept replaces the head, a bare emit empties it.
      always_comb begin
        h_d_data = bus.in_data;
        h_d_ctrl = bus.in_ctrl;
        h_load   = !flush && accept;
        h_clear  = flush || (emit && !accept);
      end
    end
  endgenerate

  // ---- output side: an invalid head always looks like a NOP ----
  assign bus.out_valid = h_valid;
  assign bus.out_ctrl  = h_valid ? h_ctrl : '0;
  assign bus.out_data  = (CLEAR_DATA != 0 && !h_valid) ? '0 : h_data;

  // Count cycles where downstream was ready but nothing was offered.
  always_comb begin
    bubble_d = bubble_q;
    if (bus.out_ready && !h_valid) bubble_d = sat_inc(bubble_q);
  end

  // Bubble counter; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bubble_q <= '0;
    else        bubble_q <= bubble_d;
  end

  assign bubble_count = bubble_q;
endmodule
